// File: rtl/pipe_addsub_pkg.sv
// Shared constants for the pipelined add/subtract unit: opcode encoding,
// default generics and the configuration legality check used at elaboration.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 2;
    localparam int DEF_TAG_W  = 4;

    function automatic bit cfg_ok(input int width, input int stages, input int tag_w);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0) && (tag_w >= 1);
    endfunction

endpackage

// File: rtl/pipe_addsub_seg.sv
// One SEG-bit carry-chain segment of the pipelined adder; purely combinational.
module pipe_addsub_seg
    import pipe_addsub_pkg::*;
#(
    parameter int SEG = DEF_WIDTH / DEF_STAGES
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipe_addsub_n.sv
// Pipelined add/subtract with ready/valid backpressure; one carry segment per stage.
// Optional unsigned saturation in the last stage when PIPE_ADDSUB_SAT_EN is defined.
module pipe_addsub_n
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    input  logic             in_sat,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES, TAG_W)) begin : g_cfg_err
        $error("pipe_addsub_n: illegal WIDTH/STAGES/TAG_W combination");
    end

    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic              r_ovf;

    // Stage inputs: index 0 comes from the ports, index k from stage register k-1.
    logic [WIDTH-1:0]  w_st_a   [STAGES];
    logic [WIDTH-1:0]  w_st_b   [STAGES];
    logic [WIDTH-1:0]  w_st_sum [STAGES];
    logic [TAG_W-1:0]  w_st_tag [STAGES];
    logic [STAGES-1:0] w_st_vld;
    logic [STAGES-1:0] w_st_cin;

    logic [SEG-1:0]    w_seg_a   [STAGES];
    logic [SEG-1:0]    w_seg_b   [STAGES];
    logic [SEG-1:0]    w_seg_sum [STAGES];
    logic [STAGES-1:0] w_seg_cout;

    logic [WIDTH-1:0]  w_nx_sum [STAGES];
    logic              w_nx_ovf;
    logic              w_advance;

`ifdef PIPE_ADDSUB_SAT_EN
    logic [STAGES-1:0] r_op;
    logic [STAGES-1:0] r_sat;
    logic [STAGES-1:0] w_st_op;
    logic [STAGES-1:0] w_st_sat;
`else
    logic w_unused_sat;
    assign w_unused_sat = in_sat;
`endif

    assign w_advance = !r_valid[LAST] || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_st_vld    = '0;
        w_st_cin    = '0;
        w_st_a[0]   = in_a;
        w_st_b[0]   = (in_op == OP_SUB) ? ~in_b : in_b;
        w_st_sum[0] = '0;
        w_st_tag[0] = in_tag;
        w_st_vld[0] = in_valid;
        w_st_cin[0] = in_cin ^ in_op;
`ifdef PIPE_ADDSUB_SAT_EN
        w_st_op     = '0;
        w_st_sat    = '0;
        w_st_op[0]  = in_op;
        w_st_sat[0] = in_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_st_a[k]   = r_a[k-1];
            w_st_b[k]   = r_b[k-1];
            w_st_sum[k] = r_sum[k-1];
            w_st_tag[k] = r_tag[k-1];
            w_st_vld[k] = r_valid[k-1];
            w_st_cin[k] = r_carry[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
            w_st_op[k]  = r_op[k-1];
            w_st_sat[k] = r_sat[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg_a[k] = w_st_a[k][k*SEG +: SEG];
            w_seg_b[k] = w_st_b[k][k*SEG +: SEG];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        pipe_addsub_seg #(.SEG(SEG)) u_seg (
            .a    (w_seg_a[g]),
            .b    (w_seg_b[g]),
            .cin  (w_st_cin[g]),
            .sum  (w_seg_sum[g]),
            .cout (w_seg_cout[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nx_sum[k]               = w_st_sum[k];
            w_nx_sum[k][k*SEG +: SEG] = w_seg_sum[k];
        end
        // Overflow is judged on the raw sum, before any clamp below.
        w_nx_ovf = (w_st_a[LAST][WIDTH-1] == w_st_b[LAST][WIDTH-1]) &&
                   (w_nx_sum[LAST][WIDTH-1] != w_st_a[LAST][WIDTH-1]);
`ifdef PIPE_ADDSUB_SAT_EN
        if (w_st_sat[LAST]) begin
            if (w_st_op[LAST] == OP_ADD && w_seg_cout[LAST]) begin
                w_nx_sum[LAST] = '1;
            end else if (w_st_op[LAST] == OP_SUB && !w_seg_cout[LAST]) begin
                w_nx_sum[LAST] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_carry <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_tag[k] <= '0;
            end
`ifdef PIPE_ADDSUB_SAT_EN
            r_op  <= '0;
            r_sat <= '0;
`endif
        end else if (w_advance) begin
            r_valid <= w_st_vld;
            r_carry <= w_seg_cout;
            r_ovf   <= w_nx_ovf;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_st_a[k];
                r_b[k]   <= w_st_b[k];
                r_sum[k] <= w_nx_sum[k];
                r_tag[k] <= w_st_tag[k];
            end
`ifdef PIPE_ADDSUB_SAT_EN
            r_op  <= w_st_op;
            r_sat <= w_st_sat;
`endif
        end
    end

    assign out_valid = r_valid[LAST];
    assign out_sum   = r_sum[LAST];
    assign out_carry = r_carry[LAST];
    assign out_ovf   = r_ovf;
    assign out_tag   = r_tag[LAST];

endmodule
